// File: rtl/clk_meter.sv
// clk_meter: synchronizes a slow asynchronous square wave and measures its
// period and high time in clkin cycles, publishing each result with a valid pulse.
//------------------------------------------------------------------------------
// Module   : clk_meter
// Purpose  : period / high-time meter for a slow asynchronous input
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_meter #(
  parameter int CNT_W = 32
) (
  input  logic             clkin,
  input  logic             clr_n,
  input  logic             sig_in,
  output logic             rise,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             ovf,
  output logic             locked
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt, hcnt, hold;
  logic             r, f;
  logic             cnt_sat, hcnt_sat;

  assign r        = s2 & ~s3;
  assign f        = ~s2 & s3;
  assign cnt_sat  = (cnt == MAX_CNT);
  assign hcnt_sat = (hcnt == MAX_CNT);
  assign locked   = (state == ARMED);

  // Synchronizer and saturating cycle counters
  always_ff @(posedge clkin or negedge clr_n) begin
    if (!clr_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      cnt  <= '0;
      hcnt <= '0;
      hold <= '0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;

      if (r)
        cnt <= ONE_CNT;
      else if (!cnt_sat)
        cnt <= cnt + ONE_CNT;

      if (r)
        hcnt <= ONE_CNT;
      else if (s2 && !hcnt_sat)
        hcnt <= hcnt + ONE_CNT;

      // hold keeps the high time of the period now in progress until its end
      if (f)
        hold <= hcnt;
    end
  end

  // Measurement FSM with registered outputs
  always_ff @(posedge clkin or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      rise      <= 1'b0;
      valid     <= 1'b0;
      period    <= '0;
      high_time <= '0;
      ovf       <= 1'b0;
    end else begin
      rise  <= r;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (r)
            state <= ARMED;
        end
        ARMED: begin
          // An edge landing on the saturation cycle still publishes
          if (r) begin
            period    <= cnt;
            high_time <= hold;
            valid     <= 1'b1;
            if (cnt_sat)
              ovf <= 1'b1;
          end else if (cnt_sat) begin
            state <= STALL;
            ovf   <= 1'b1;
          end
        end
        STALL: begin
          if (r)
            state <= ARMED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_meter.sv
// tb_clk_meter: randomized phase-sequence stimulus with a scoreboard of
// expected per-rise results derived from phase lengths.
//------------------------------------------------------------------------------
// Module   : tb_clk_meter
// Purpose  : self-checking bench for clk_meter (CNT_W = 8)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_meter;

  localparam int CNT_W = 8;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clkin = 1'b0;
  logic             clr_n = 1'b0;
  logic             sig_in = 1'b0;
  logic             rise, valid, ovf, locked;
  logic [CNT_W-1:0] period, high_time;

  clk_meter #(.CNT_W(CNT_W)) dut (
    .clkin     (clkin),
    .clr_n     (clr_n),
    .sig_in    (sig_in),
    .rise      (rise),
    .valid     (valid),
    .period    (period),
    .high_time (high_time),
    .ovf       (ovf),
    .locked    (locked)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    bit v;
    int p;
    int h;
    bit o;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  bit   cur_level;
  int   hi_len, lo_len;
  bit   had_rise, ovf_m;
  int   last_p, last_h;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one phase of n cycles; a low-to-high step closes the previous period
  task automatic drive_phase(input bit level, input int n, input bit lat);
    if (level && !cur_level) begin
      exp_t e;
      int   p;
      p = hi_len + lo_len;
      if (had_rise && p > MAX + 4) begin
        check("stall_locked", locked, 0);
        check("stall_ovf", ovf, 1);
      end
      if (had_rise && p >= MAX) ovf_m = 1'b1;
      e.v = had_rise && (p <= MAX);
      e.p = p;
      e.h = (hi_len > MAX) ? MAX : hi_len;
      e.o = ovf_m;
      q.push_back(e);
      had_rise = 1'b1;
      hi_len = 0;
      lo_len = 0;
    end
    cur_level = level;
    sig_in = level;
    if (level) hi_len += n;
    else       lo_len += n;
    for (int k = 1; k <= n; k++) begin
      @(posedge clkin);
      #1;
      if (lat && k <= 4)
        check($sformatf("latency_rise_edge%0d", k), rise, (k == 3));
    end
    #1;
  endtask

  task automatic square(input int h, input int l, input int reps);
    repeat (reps) begin
      drive_phase(1'b1, h, 1'b0);
      drive_phase(1'b0, l, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise"}, rise, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_high_time"}, high_time, 0);
  endtask

  // Monitor: every rise consumes one expected record
  always @(negedge clkin) begin
    if (!clr_n) begin
      last_p = 0;
      last_h = 0;
    end else begin
      if (valid && !rise)
        check("valid_without_rise", valid, 0);
      if (rise) begin
        if (q.size() == 0) begin
          check("unexpected_rise", rise, 0);
        end else begin
          mon_e = q.pop_front();
          check("valid", valid, mon_e.v);
          check("locked", locked, 1);
          check("ovf", ovf, mon_e.o);
          if (mon_e.v) begin
            check("period", period, mon_e.p);
            check("high_time", high_time, mon_e.h);
          end
        end
      end else begin
        check("period_stable", period, last_p);
        check("high_time_stable", high_time, last_h);
      end
      last_p = period;
      last_h = high_time;
    end
  end

  initial begin
    int h, l;
    cur_level = 1'b0;
    hi_len = 0;
    lo_len = 0;
    had_rise = 1'b0;
    ovf_m = 1'b0;

    repeat (3) @(posedge clkin);
    #1;
    check_all_zero("reset");
    #1;
    clr_n = 1'b1;
    drive_phase(1'b0, 3, 1'b0);

    // 4 high / 6 low, first rise also checked for latency
    drive_phase(1'b1, 4, 1'b1);
    drive_phase(1'b0, 6, 1'b0);
    square(4, 6, 5);

    // minimum legal phases
    square(2, 2, 8);

    // 10/10 then 3 high / 5 low
    square(10, 10, 3);
    drive_phase(1'b1, 10, 1'b0);
    drive_phase(1'b0, 3, 1'b0);
    square(3, 5, 3);

    // long low phase saturates the counter
    drive_phase(1'b1, 5, 1'b0);
    drive_phase(1'b0, 300, 1'b0);
    square(5, 5, 4);

    // random phases
    repeat (40) begin
      h = $urandom_range(2, 20);
      l = $urandom_range(2, 20);
      square(h, l, 1);
    end

    // asynchronous reset in the middle of a high phase
    drive_phase(1'b1, 6, 1'b0);
    clr_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sig_in = 1'b0;
    cur_level = 1'b0;
    hi_len = 0;
    lo_len = 0;
    had_rise = 1'b0;
    ovf_m = 1'b0;
    q.delete();
    repeat (3) @(posedge clkin);
    #2;
    clr_n = 1'b1;
    drive_phase(1'b0, 4, 1'b0);
    square(4, 6, 4);

    // periods just below and exactly at the saturation value
    drive_phase(1'b1, 100, 1'b0);
    drive_phase(1'b0, 154, 1'b0);
    drive_phase(1'b1, 100, 1'b0);
    drive_phase(1'b0, 155, 1'b0);
    square(5, 5, 3);

    drive_phase(1'b1, 5, 1'b0);
    drive_phase(1'b0, 5, 1'b0);
    repeat (5) @(posedge clkin);
    #1;
    check("drain_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
